// File: rtl/ex_stage_if.sv
// ex_stage_if
// Bundles the ID/EX pipeline register outputs, the WB forwarding source and
// the EX/MEM pipeline register outputs of the SIMD-AES execute stage.
// Ports (all carried as interface signals):
//   EX_*   operands, register indices and control bits from the ID/EX register
//   WB_*   writeback-stage forwarding source
//   MEM_*  registered result, store data and control into the MEM stage
//   stall  hold request back to IF/ID and ID/EX
// The slave modport is the execute stage. The master modport is whatever
// drives the ID/EX side and observes EX/MEM.
interface ex_stage_if;
  logic [31:0] EX_data1;
  logic [31:0] EX_data2;
  logic [31:0] EX_Imm;
  logic [4:0]  EX_rd;
  logic [4:0]  EX_rs1;
  logic [4:0]  EX_rs2;
  logic [2:0]  EX_ALUControl;
  logic        EX_RegWrite;
  logic        EX_MemWrite;
  logic        EX_ALUScr;
  logic        EX_VRegWrite;
  logic [1:0]  EX_MemToReg;
  logic [4:0]  WB_rd;
  logic        WB_RegWrite;
  logic [31:0] WB_Result;
  logic        stall;
  logic [31:0] MEM_ALUResult;
  logic [31:0] MEM_WriteData;
  logic [4:0]  MEM_rd;
  logic [1:0]  MEM_MemToReg;
  logic        MEM_RegWrite;
  logic        MEM_MemWrite;
  logic        MEM_VRegWrite;

  modport master (
    output EX_data1, EX_data2, EX_Imm, EX_rd, EX_rs1, EX_rs2, EX_ALUControl,
           EX_RegWrite, EX_MemWrite, EX_ALUScr, EX_VRegWrite, EX_MemToReg,
           WB_rd, WB_RegWrite, WB_Result,
    input  stall, MEM_ALUResult, MEM_WriteData, MEM_rd, MEM_MemToReg,
           MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite
  );

  modport slave (
    input  EX_data1, EX_data2, EX_Imm, EX_rd, EX_rs1, EX_rs2, EX_ALUControl,
           EX_RegWrite, EX_MemWrite, EX_ALUScr, EX_VRegWrite, EX_MemToReg,
           WB_rd, WB_RegWrite, WB_Result,
    output stall, MEM_ALUResult, MEM_WriteData, MEM_rd, MEM_MemToReg,
           MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage of the SIMD-AES pipeline. Resolves operands through MEM/WB
// forwarding, runs the scalar ALU or an iterative 4-lane GF(2^8) multiplier
// (polynomial 0x11B, used for MixColumns) and registers the result into the
// EX/MEM pipeline register. A gfmul takes 9 cycles; stall is held for the
// first 8 so upstream stages keep the instruction in place.
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    ex_stage_if.slave: EX_* / WB_* inputs, MEM_* and stall outputs
module ex_stage (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  logic [0:0]  state;
  logic [2:0]  cnt;
  logic [31:0] a_reg, b_reg, p_reg;
  logic [31:0] a_next, b_next, p_next;

  logic [31:0] fwd_a, fwd_b, op_b, alu_result;
  logic        start;

  logic [31:0] mem_alu_result, mem_write_data;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_mem_to_reg;
  logic        mem_reg_write, mem_mem_write, mem_vreg_write;

  // MEM forwarding only applies to ALU results (MemToReg=00); loads are
  // kept out of this stage by the upstream hazard unit.
  always_comb begin
    fwd_a = bus.EX_data1;
    if (bus.EX_rs1 != 5'd0 && mem_reg_write && mem_rd == bus.EX_rs1 &&
        mem_mem_to_reg == 2'b00)
      fwd_a = mem_alu_result;
    else if (bus.EX_rs1 != 5'd0 && bus.WB_RegWrite && bus.WB_rd == bus.EX_rs1)
      fwd_a = bus.WB_Result;

    fwd_b = bus.EX_data2;
    if (bus.EX_rs2 != 5'd0 && mem_reg_write && mem_rd == bus.EX_rs2 &&
        mem_mem_to_reg == 2'b00)
      fwd_b = mem_alu_result;
    else if (bus.EX_rs2 != 5'd0 && bus.WB_RegWrite && bus.WB_rd == bus.EX_rs2)
      fwd_b = bus.WB_Result;

    op_b = bus.EX_ALUScr ? bus.EX_Imm : fwd_b;
  end

  // Op 111 without a write enable is a bubble and yields zero here.
  always_comb begin
    alu_result = 32'd0;
    case (bus.EX_ALUControl)
      3'b000:  alu_result = fwd_a + op_b;
      3'b001:  alu_result = fwd_a - op_b;
      3'b010:  alu_result = fwd_a & op_b;
      3'b011:  alu_result = fwd_a | op_b;
      3'b100:  alu_result = fwd_a ^ op_b;
      3'b101:  alu_result = fwd_a << op_b[4:0];
      3'b110:  alu_result = fwd_a >> op_b[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  // One shift-and-add step per lane; a is reduced by 0x1B when its top bit
  // falls out, which is multiplication by x modulo 0x11B.
  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    p_next = p_reg;
    for (int i = 0; i < 4; i++) begin
      if (b_reg[8*i])
        p_next[8*i +: 8] = p_reg[8*i +: 8] ^ a_reg[8*i +: 8];
      a_next[8*i +: 8] = {a_reg[8*i +: 7], 1'b0} ^
                         (a_reg[8*i+7] ? 8'h1B : 8'h00);
      b_next[8*i +: 8] = {1'b0, b_reg[8*i+1 +: 7]};
    end
  end

  assign start = (state == IDLE) && (bus.EX_ALUControl == 3'b111) &&
                 (bus.EX_RegWrite || bus.EX_VRegWrite);

  // Gated by rst_n so an aborted multiply releases upstream immediately.
  assign bus.stall = rst_n && (start || (state == MUL && cnt != 3'd7));

  // The final iteration result (p_next at cnt=7) is written straight into
  // EX/MEM, so the result needs no extra cycle in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      p_reg          <= 32'd0;
      mem_alu_result <= 32'd0;
      mem_write_data <= 32'd0;
      mem_rd         <= 5'd0;
      mem_mem_to_reg <= 2'b00;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_vreg_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= fwd_a;
            b_reg <= op_b;
            p_reg <= 32'd0;
            cnt   <= 3'd0;
            state <= MUL;
          end
        end
        default: begin
          a_reg <= a_next;
          b_reg <= b_next;
          p_reg <= p_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7)
            state <= IDLE;
        end
      endcase

      if (bus.stall) begin
        mem_alu_result <= 32'd0;
        mem_write_data <= 32'd0;
        mem_rd         <= 5'd0;
        mem_mem_to_reg <= 2'b00;
        mem_reg_write  <= 1'b0;
        mem_mem_write  <= 1'b0;
        mem_vreg_write <= 1'b0;
      end else begin
        mem_alu_result <= (state == MUL) ? p_next : alu_result;
        mem_write_data <= fwd_b;
        mem_rd         <= bus.EX_rd;
        mem_mem_to_reg <= bus.EX_MemToReg;
        mem_reg_write  <= bus.EX_RegWrite;
        mem_mem_write  <= bus.EX_MemWrite;
        mem_vreg_write <= bus.EX_VRegWrite;
      end
    end
  end

  assign bus.MEM_ALUResult = mem_alu_result;
  assign bus.MEM_WriteData = mem_write_data;
  assign bus.MEM_rd        = mem_rd;
  assign bus.MEM_MemToReg  = mem_mem_to_reg;
  assign bus.MEM_RegWrite  = mem_reg_write;
  assign bus.MEM_MemWrite  = mem_mem_write;
  assign bus.MEM_VRegWrite = mem_vreg_write;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
// Directed bench for ex_stage: a table of scalar/forwarding vectors plus
// hand-written sequences for reset, gfmul, back-to-back gfmul and reset
// during a multiply.
module tb_ex_stage;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [31:0] wb_res;
    logic [31:0] exp_res;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[15];

  // Drives one ID/EX instruction plus the WB forwarding source.
  task automatic applyStimulus(input vec_t v);
    bus.EX_ALUControl = v.op;
    bus.EX_data1      = v.d1;
    bus.EX_data2      = v.d2;
    bus.EX_Imm        = v.imm;
    bus.EX_ALUScr     = v.src;
    bus.EX_rs1        = v.rs1;
    bus.EX_rs2        = v.rs2;
    bus.EX_rd         = v.rd;
    bus.EX_RegWrite   = v.rw;
    bus.EX_MemWrite   = v.mw;
    bus.EX_VRegWrite  = 1'b0;
    bus.EX_MemToReg   = 2'b00;
    bus.WB_rd         = v.wb_rd;
    bus.WB_RegWrite   = v.wb_rw;
    bus.WB_Result     = v.wb_res;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBubble(input string name);
    checkOutput({name, " result"},   bus.MEM_ALUResult, 32'd0);
    checkOutput({name, " wdata"},    bus.MEM_WriteData, 32'd0);
    checkOutput({name, " rd"},       {27'd0, bus.MEM_rd}, 32'd0);
    checkOutput({name, " ctrl"},
                {27'd0, bus.MEM_MemToReg, bus.MEM_RegWrite,
                 bus.MEM_MemWrite, bus.MEM_VRegWrite}, 32'd0);
  endtask

  // Runs one gfmul of 0x5702FF01 * 0x83030101 and checks 8 stall cycles with
  // bubbles, then the result on the 9th edge. Inputs are left presenting the
  // gfmul, so a following call exercises back-to-back starts.
  task automatic runGfmul(input string name);
    vec_t g;
    g = '{3'b111, 32'h5702FF01, 32'h83030101, 32'h0, 1'b0, 5'd0, 5'd0,
          5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0};
    applyStimulus(g);
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("%s stall E%0d", name, i), {31'd0, bus.stall}, 32'd1);
      @(posedge clk);
      #1;
      checkBubble($sformatf("%s bubble E%0d", name, i));
    end
    checkOutput({name, " stall E8"}, {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " result"}, bus.MEM_ALUResult, 32'hC106FF01);
    checkOutput({name, " rd"}, {27'd0, bus.MEM_rd}, 32'd9);
    checkOutput({name, " regwrite"}, {31'd0, bus.MEM_RegWrite}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    //        op      d1            d2            imm           src  rs1   rs2   rd    rw    mw    wb_rd wb_rw wb_res       exp_res       exp_wd
    vecs[0]  = '{3'b000, 32'h1,        32'h2,        32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'h3,        32'h2};
    vecs[1]  = '{3'b000, 32'h99,       32'hA,        32'h0,        1'b0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'hD,        32'hA};
    vecs[2]  = '{3'b000, 32'h1,        32'h2,        32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'h3,        32'h2};
    vecs[3]  = '{3'b000, 32'h99,       32'hA,        32'h0,        1'b0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 32'h50,      32'hD,        32'hA};
    vecs[4]  = '{3'b000, 32'h7,        32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'h7,        32'h0};
    vecs[5]  = '{3'b000, 32'h20,       32'h1,        32'h0,        1'b0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 32'h50,      32'h21,       32'h1};
    vecs[6]  = '{3'b000, 32'h5,        32'h0,        32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'h4,        32'h0};
    vecs[7]  = '{3'b001, 32'h0,        32'h1,        32'h0,        1'b0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'hFFFFFFFF, 32'h1};
    vecs[8]  = '{3'b101, 32'h80000001, 32'h0,        32'd33,       1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'h2,        32'h0};
    vecs[9]  = '{3'b110, 32'h80000001, 32'h0,        32'd33,       1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'h40000000, 32'h0};
    vecs[10] = '{3'b010, 32'hF0F0,     32'hFF00,     32'h0,        1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'hF000,     32'hFF00};
    vecs[11] = '{3'b011, 32'hF0F0,     32'hFF00,     32'h0,        1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'hFFF0,     32'hFF00};
    vecs[12] = '{3'b100, 32'hF0F0,     32'hFF00,     32'h0,        1'b0, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,       32'h0FF0,     32'hFF00};
    vecs[13] = '{3'b000, 32'h1,        32'h7,        32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 32'h100,     32'h101,      32'h100};
    vecs[14] = '{3'b000, 32'h2,        32'h3,        32'h0,        1'b0, 5'd8, 5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,       32'h5,        32'h3};

    // Reset with arbitrary (and gfmul-looking) inputs.
    rv = '{3'b111, 32'hDEADBEEF, 32'h12345678, 32'h1, 1'b0, 5'd2, 5'd3,
           5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 32'h77, 32'h0, 32'h0};
    applyStimulus(rv);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stall in reset", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    checkBubble("reset");
    checkOutput("stall in reset 2", {31'd0, bus.stall}, 32'd0);
    rst_n = 1'b1;

    // Table-driven scalar and forwarding vectors, one cycle latency each.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d stall", i), {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d result", i), bus.MEM_ALUResult, vecs[i].exp_res);
      checkOutput($sformatf("v%0d wdata", i), bus.MEM_WriteData, vecs[i].exp_wd);
      checkOutput($sformatf("v%0d rd", i), {27'd0, bus.MEM_rd}, {27'd0, vecs[i].rd});
      checkOutput($sformatf("v%0d ctrl", i),
                  {30'd0, bus.MEM_RegWrite, bus.MEM_MemWrite},
                  {30'd0, vecs[i].rw, vecs[i].mw});
    end

    // Op 111 with no write enable is a bubble: no stall, no write.
    rv = '{3'b111, 32'h5, 32'h6, 32'h0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0,
           5'd0, 1'b0, 32'h0, 32'h0, 32'h0};
    applyStimulus(rv);
    #1;
    checkOutput("nop111 stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("nop111 regwrite", {31'd0, bus.MEM_RegWrite}, 32'd0);
    checkOutput("nop111 stall after", {31'd0, bus.stall}, 32'd0);

    // gfmul, then an immediate back-to-back second gfmul.
    runGfmul("gf1");
    runGfmul("gf2");

    // Abort a multiply mid-flight with reset.
    rv = '{3'b111, 32'h5702FF01, 32'h83030101, 32'h0, 1'b0, 5'd0, 5'd0,
           5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0};
    applyStimulus(rv);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("mid stall before reset", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid stall in reset", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    checkBubble("mid reset");
    @(posedge clk);
    #1;
    checkBubble("mid reset 2");
    rst_n = 1'b1;
    runGfmul("gf3");

    // Return to a scalar op after the multiply.
    applyStimulus(vecs[0]);
    @(posedge clk);
    #1;
    checkOutput("post gf add", bus.MEM_ALUResult, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
